rng_monobit_test: RTL and testbench
===================================

Name: rng_monobit_test

Overview:
- Frequency (monobit) statistical tester that sits directly downstream of the Mersenne-Twister generator.
- Consumes its 4x32-bit output beat whenever the generator is enabled and its test-enable flag is high.
- Counts ones over fixed windows of 2^LOG2_BLOCKS beats and reports a pass/fail verdict per window against a two-sided threshold on |#ones − #zeros|.
- Keeps running window and failure tallies for readout by the analysis host logic.

Parameters:
- LOG2_BLOCKS, 10: log2 of 128-bit beats per window. Window = 128·2^LOG2_BLOCKS bits; window bit count is NBITS.
- THRESH, 1191: maximum passing |2·ones − NBITS|. The default is ≈3.29·sqrt(NBITS), α≈0.001 at default size.
- CNT_W, 16: width of the window and failure tallies.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- enable  in  1  generator advance strobe, shared with upstream
- tst_en  in  1  upstream output-valid flag
- data  in  [31:0] x4 (unpacked [3:0])  upstream random words
- clear  in  1  synchronous restart of window and tallies
- done  out  1  one-cycle pulse: verdict for a finished window is valid
- pass  out  1  verdict of last finished window (1 = pass)
- ones  out  LOG2_BLOCKS+8  ones count of last finished window
- win_cnt  out  CNT_W  windows evaluated, saturating
- fail_cnt  out  CNT_W  windows failed, saturating

Behaviour:
- Reset (rst low, asynchronous): done=0, pass=0, ones=0, win_cnt=0, fail_cnt=0. All internal state clears: accumulator, beat counter, valid pipeline.
- Beat accepted at a rising edge iff enable & tst_en & ~clear. Words are sampled as presented; no handshake back to upstream. The block never stalls.
- Pipeline; all stages advance every cycle and bubbles carry valid=0.
  - Stage 1 (edge E0): pc_r ← popcount of all 128 bits (0..128, 8 bits); v1 ← accepted.
  - Stage 2 (edge E1), if v1:
    - If beat == 2^LOG2_BLOCKS−1: res ← acc+pc_r; acc ← 0; beat ← 0; ev ← 1.
    - Otherwise: acc ← acc+pc_r; beat ← beat+1.
  - Stage 3 (edge E2), if ev:
    - ones ← res.
    - diff = |2·res − NBITS|, computed at LOG2_BLOCKS+10 bits signed with no overflow.
    - pass ← (diff ≤ THRESH).
    - done ← 1 for exactly one cycle.
    - win_cnt +1 and, on failure, fail_cnt +1. Both hold at all-ones (saturate).
- Latency: done is high in the cycle after E2, i.e. 2 edges after the edge that accepts the window's last beat.
- Windows are back-to-back. The first beat of the next window can be accepted at E0+1 with no dead cycles.
- Gaps (enable or tst_en low) do not count. The window spans exactly 2^LOG2_BLOCKS accepted beats regardless of gaps.
- acc width LOG2_BLOCKS+8. Max value NBITS fits; no wrap.
- clear (synchronous, priority over accept):
  - Zeroes acc, beat, v1, ev, win_cnt and fail_cnt.
  - ones and pass hold their values; done is forced to 0.
  - Any in-flight window is discarded and produces no done.
- An asynchronous reset mid-window discards the window. After release, counting restarts at beat 0 on the next accepted beat.
- ones, pass and diff are stable between done pulses.

Test Plan (LOG2_BLOCKS=2, NBITS=512, THRESH=64):
- Four accepted beats, all words 0xAAAAAAAA → done 2 edges after 4th accept; ones=256, pass=1, win_cnt=1, fail_cnt=0.
- Four beats all 0xFFFFFFFF → ones=512, diff=512, pass=0, fail_cnt=1. Follow with four all-zero beats → ones=0, pass=0, fail_cnt=2, win_cnt=2.
- Threshold edge: 0xAAAAAAAA beats with two words replaced by 0xFFFFFFFF → ones=288, diff=64, pass=1. Additionally replace one word with 0xAAAAAAAB → ones=289, diff=66, pass=0.
- Gaps: drop enable for 3 cycles and tst_en for 2 cycles between beats 2 and 3 → data on gap cycles ignored, same verdict as gap-free run, done delayed by 5 cycles.
- Back-to-back: 12 consecutive accepted beats → exactly three done pulses, 4 cycles apart, win_cnt=3.
- Mid-window events:
  - Assert clear after beat 3, then supply 4 beats of 0xAAAAAAAA → only one done, ones=256, win_cnt=1.
  - Pull rst low asynchronously mid-cycle → all outputs 0 immediately.

Source files
------------

// File: rtl/rng_monobit_test_if.sv
// Beat and verdict signals between the random generator, the monobit tester and the host.
// The master drives beats and clear. The slave (the tester) returns the verdict and the tallies.
interface rng_monobit_test_if #(
   parameter int LOG2_BLOCKS = 10,
   parameter int CNT_W       = 16
);
   logic                   enable;
   logic                   tst_en;
   logic [31:0]            data [3:0];
   logic                   clear;
   logic                   done;
   logic                   pass;
   logic [LOG2_BLOCKS+7:0] ones;
   logic [CNT_W-1:0]       win_cnt;
   logic [CNT_W-1:0]       fail_cnt;

   modport master (
      output enable, tst_en, data, clear,
      input  done, pass, ones, win_cnt, fail_cnt
   );

   modport slave (
      input  enable, tst_en, data, clear,
      output done, pass, ones, win_cnt, fail_cnt
   );
endinterface

// File: rtl/rng_monobit_test.sv
// Monobit frequency tester: counts ones over windows of 2^LOG2_BLOCKS 128-bit beats.
// It reports a pass/fail verdict per window and keeps saturating window and failure tallies.
module rng_monobit_test #(
   parameter int LOG2_BLOCKS = 10,
   parameter int THRESH      = 1191,
   parameter int CNT_W       = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   rng_monobit_test_if.slave     bus
);
   localparam int NBITS = 128 << LOG2_BLOCKS;
   localparam int AW    = LOG2_BLOCKS + 8;
   localparam int DW    = LOG2_BLOCKS + 10;

   logic                   accept;
   logic [7:0]             pc_nxt;
   logic [7:0]             pc_r;
   logic                   v1;
   logic                   ev;
   logic [LOG2_BLOCKS-1:0] beat;
   logic [AW-1:0]          acc;
   logic [AW-1:0]          res;
   logic signed [DW-1:0]   dsig;
   logic [DW-1:0]          diff;
   logic                   done_r;
   logic                   pass_r;
   logic [AW-1:0]          ones_r;
   logic [CNT_W-1:0]       win_r;
   logic [CNT_W-1:0]       fail_r;

   assign accept = bus.enable & bus.tst_en & ~bus.clear;

   always_comb begin
      pc_nxt = '0;
      for (int w = 0; w < 4; w++) begin
         for (int b = 0; b < 32; b++) begin
            pc_nxt = pc_nxt + 8'(bus.data[w][b]);
         end
      end
   end

   // Signed compare of 2*ones against NBITS. res holds between windows, so diff is stable.
   always_comb begin
      dsig = $signed({1'b0, res, 1'b0}) - $signed(DW'(NBITS));
      diff = dsig[DW-1] ? $unsigned(-dsig) : $unsigned(dsig);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pc_r   <= '0;
         v1     <= 1'b0;
         ev     <= 1'b0;
         beat   <= '0;
         acc    <= '0;
         res    <= '0;
         done_r <= 1'b0;
         pass_r <= 1'b0;
         ones_r <= '0;
         win_r  <= '0;
         fail_r <= '0;
      end else begin
         pc_r   <= pc_nxt;
         done_r <= 1'b0;
         if (bus.clear) begin
            v1     <= 1'b0;
            ev     <= 1'b0;
            beat   <= '0;
            acc    <= '0;
            win_r  <= '0;
            fail_r <= '0;
         end else begin
            v1 <= accept;
            ev <= 1'b0;
            if (v1) begin
               if (&beat) begin
                  res  <= acc + AW'(pc_r);
                  acc  <= '0;
                  beat <= '0;
                  ev   <= 1'b1;
               end else begin
                  acc  <= acc + AW'(pc_r);
                  beat <= beat + 1'b1;
               end
            end
            if (ev) begin
               ones_r <= res;
               pass_r <= (diff <= DW'(THRESH));
               done_r <= 1'b1;
               if (~&win_r) win_r <= win_r + 1'b1;
               if ((diff > DW'(THRESH)) && ~&fail_r) fail_r <= fail_r + 1'b1;
            end
         end
      end
   end

   assign bus.done     = done_r;
   assign bus.pass     = pass_r;
   assign bus.ones     = ones_r;
   assign bus.win_cnt  = win_r;
   assign bus.fail_cnt = fail_r;
endmodule

// File: tb/tb_rng_monobit_test.sv
// Bench for rng_monobit_test at LOG2_BLOCKS=2, THRESH=64, CNT_W=4: directed windows plus random traffic,
// checked every cycle against a window-level reference model.
module tb_rng_monobit_test;
   localparam int L      = 2;
   localparam int THRESH = 64;
   localparam int CNT_W  = 4;
   localparam int NBEATS = 1 << L;
   localparam int NBITS  = 128 * NBEATS;
   localparam int CMAX   = (1 << CNT_W) - 1;

   logic clk = 1'b0;
   logic rst = 1'b0;

   rng_monobit_test_if #(.LOG2_BLOCKS(L), .CNT_W(CNT_W)) bus ();

   rng_monobit_test #(.LOG2_BLOCKS(L), .THRESH(THRESH), .CNT_W(CNT_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   int cyc = 0;
   int m_sum = 0, m_n = 0;
   int m_ones = 0, m_pass = 0, m_win = 0, m_fail = 0;
   int pend_cyc[$];
   int pend_sum[$];
   int done_seen = 0;

   task automatic chk(input string tag, input int got, input int exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic logic [127:0] fill(input logic [31:0] w);
      return {w, w, w, w};
   endfunction

   // Reference model: one call per clock edge, using the inputs that were applied before that edge.
   task automatic model_step(input logic en, input logic te, input logic clr, input logic [127:0] d);
      bit exp_done;
      int s, dd;
      cyc++;
      if (clr) begin
         pend_cyc.delete();
         pend_sum.delete();
         m_sum = 0; m_n = 0; m_win = 0; m_fail = 0;
      end else if (en && te) begin
         m_sum += $countones(d);
         m_n++;
         if (m_n == NBEATS) begin
            pend_cyc.push_back(cyc + 2);
            pend_sum.push_back(m_sum);
            m_sum = 0;
            m_n = 0;
         end
      end
      exp_done = (pend_cyc.size() > 0) && (pend_cyc[0] == cyc);
      if (exp_done) begin
         void'(pend_cyc.pop_front());
         s = pend_sum.pop_front();
         dd = 2 * s - NBITS;
         if (dd < 0) dd = -dd;
         m_ones = s;
         m_pass = (dd <= THRESH) ? 1 : 0;
         if (m_win < CMAX) m_win++;
         if (!m_pass && m_fail < CMAX) m_fail++;
      end
      if (bus.done) done_seen++;
      chk("done", int'(bus.done), int'(exp_done));
      chk("ones", int'(bus.ones), m_ones);
      chk("pass", int'(bus.pass), m_pass);
      chk("win_cnt", int'(bus.win_cnt), m_win);
      chk("fail_cnt", int'(bus.fail_cnt), m_fail);
   endtask

   task automatic drive(input logic en, input logic te, input logic clr, input logic [127:0] d);
      bus.enable = en;
      bus.tst_en = te;
      bus.clear  = clr;
      for (int w = 0; w < 4; w++) bus.data[w] = d[32*w +: 32];
      @(posedge clk);
      #1;
      model_step(en, te, clr, d);
   endtask

   task automatic beats(input int n, input logic [127:0] d);
      for (int i = 0; i < n; i++) drive(1'b1, 1'b1, 1'b0, d);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, {4{$urandom()}});
   endtask

   function automatic logic [31:0] rand_word();
      case ($urandom_range(0, 5))
         0:       return 32'hFFFF_FFFF;
         1:       return 32'h0000_0000;
         default: return $urandom();
      endcase
   endfunction

   task automatic random_run(input int n, input int clr_odds);
      logic [127:0] d;
      for (int i = 0; i < n; i++) begin
         d = {rand_word(), rand_word(), rand_word(), rand_word()};
         drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 4) != 0),
               1'($urandom_range(0, clr_odds) == 0), d);
      end
   endtask

   logic [127:0] pat;
   int ds0;

   initial begin
      bus.enable = 1'b0;
      bus.tst_en = 1'b0;
      bus.clear  = 1'b0;
      for (int w = 0; w < 4; w++) bus.data[w] = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_done", int'(bus.done), 0);
      chk("rst_pass", int'(bus.pass), 0);
      chk("rst_ones", int'(bus.ones), 0);
      chk("rst_win", int'(bus.win_cnt), 0);
      chk("rst_fail", int'(bus.fail_cnt), 0);
      rst = 1'b1;

      // Balanced window: 256 ones, pass.
      beats(4, fill(32'hAAAA_AAAA));
      idle(3);
      chk("bal_ones", int'(bus.ones), 256);

      // All ones, then all zeros: both fail.
      beats(4, fill(32'hFFFF_FFFF));
      idle(3);
      beats(4, fill(32'h0000_0000));
      idle(3);
      chk("ext_fail", int'(bus.fail_cnt), 2);

      // Threshold edge: 288 ones (diff 64) passes, 289 ones (diff 66) fails.
      pat = fill(32'hAAAA_AAAA);
      pat[31:0]  = 32'hFFFF_FFFF;
      pat[63:32] = 32'hFFFF_FFFF;
      beats(1, pat);
      beats(3, fill(32'hAAAA_AAAA));
      idle(3);
      chk("edge_pass", int'(bus.pass), 1);
      pat[95:64] = 32'hAAAA_AAAB;
      beats(1, pat);
      beats(3, fill(32'hAAAA_AAAA));
      idle(3);
      chk("edge_fail", int'(bus.pass), 0);

      // Gaps between beats 2 and 3 carry garbage that must be ignored.
      beats(2, fill(32'hAAAA_AAAA));
      for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 1'b0, fill(32'hFFFF_FFFF));
      for (int i = 0; i < 2; i++) drive(1'b1, 1'b0, 1'b0, fill(32'hFFFF_FFFF));
      beats(2, fill(32'hAAAA_AAAA));
      idle(3);
      chk("gap_ones", int'(bus.ones), 256);

      // Back-to-back: three windows from 12 consecutive beats.
      drive(1'b0, 1'b0, 1'b1, '0);
      ds0 = done_seen;
      beats(12, fill(32'h5555_AAAA));
      idle(3);
      chk("b2b_dones", done_seen - ds0, 3);
      chk("b2b_win", int'(bus.win_cnt), 3);

      // Clear mid-window discards it.
      beats(3, fill(32'hFFFF_FFFF));
      drive(1'b1, 1'b1, 1'b1, fill(32'hFFFF_FFFF));
      ds0 = done_seen;
      beats(4, fill(32'hAAAA_AAAA));
      idle(3);
      chk("clr_dones", done_seen - ds0, 1);
      chk("clr_win", int'(bus.win_cnt), 1);

      random_run(300, 60);

      // Asynchronous reset mid-window and mid-cycle.
      beats(2, fill(32'hFFFF_FFFF));
      bus.enable = 1'b1;
      bus.tst_en = 1'b1;
      #3;
      rst = 1'b0;
      #1;
      chk("arst_pass", int'(bus.pass), 0);
      chk("arst_ones", int'(bus.ones), 0);
      chk("arst_win", int'(bus.win_cnt), 0);
      chk("arst_fail", int'(bus.fail_cnt), 0);
      bus.enable = 1'b0;
      bus.tst_en = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b1;
      pend_cyc.delete();
      pend_sum.delete();
      m_sum = 0; m_n = 0; m_ones = 0; m_pass = 0; m_win = 0; m_fail = 0;
      beats(4, fill(32'hAAAA_AAAA));
      idle(3);
      chk("post_rst_win", int'(bus.win_cnt), 1);

      // Long run with rare clears so the tallies saturate.
      random_run(700, 2000);
      beats(80, fill(32'hFFFF_FFFF));
      idle(3);
      chk("sat_win", int'(bus.win_cnt), CMAX);
      chk("sat_fail", int'(bus.fail_cnt), CMAX);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
